// File: rtl/prng_share_if.sv
`default_nettype none
// ============================================================================
// Module      : prng_share_if
// Description : Request/reseed/result bundle for the shared xorshift32 PRNG.
// Revision    : 1.0 - initial release
// ============================================================================
interface prng_share_if #(
    parameter int NREQ = 3
);
    localparam int c_IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  seed_we;
    logic [31:0]      seed_data;
    logic [NREQ-1:0]  gnt;
    logic             rnd_valid;
    logic [31:0]      rnd_data;
    logic [c_IDW-1:0] rnd_id;

    modport master (
        output req, seed_we, seed_data,
        input  gnt, rnd_valid, rnd_data, rnd_id
    );

    modport slave (
        input  req, seed_we, seed_data,
        output gnt, rnd_valid, rnd_data, rnd_id
    );
endinterface
`default_nettype wire

// File: rtl/prng_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prng_share_ctrl
// Description : One xorshift32 step shared round-robin among NREQ requesters,
//               each with a private state. PRNG_SHARE_STATS_EN adds counters.
// Revision    : 1.0 - initial release
// ============================================================================
module prng_share_ctrl #(
    parameter int          NREQ         = 3,
    parameter logic [31:0] DEFAULT_SEED = 32'h0000_0001
) (
    input  wire logic   clk,
    input  wire logic   rst,
    prng_share_if.slave bus
`ifdef PRNG_SHARE_STATS_EN
    ,
    output logic [NREQ*16-1:0] gnt_count
`endif
);
    localparam int c_IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_ISSUE = 1'b1;

    logic [0:0]       r_fsm;
    logic [0:0]       w_fsm_next;
    logic [31:0]      r_prng [NREQ];
    logic [31:0]      r_rnd_data;
    logic [c_IDW-1:0] r_rnd_id;
    logic [c_IDW-1:0] r_last;

    logic [NREQ-1:0]  w_elig;
    logic             w_found;
    logic [c_IDW-1:0] w_win;
    logic [c_IDW:0]   w_idx;
    logic [31:0]      w_step;
    logic [31:0]      w_seed;

    function automatic logic [31:0] f_step(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // A reseeding requester is never eligible in the same cycle.
    assign w_elig = bus.req & ~bus.seed_we;
    assign w_seed = (bus.seed_data == 32'h0) ? DEFAULT_SEED : bus.seed_data;
    assign w_step = f_step(r_prng[w_win]);

    // Round-robin search beginning one past the last winner, wrapping mod NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = {1'b0, r_last} + (c_IDW+1)'(k);
            if (w_idx >= (c_IDW+1)'(NREQ)) begin
                w_idx = w_idx - (c_IDW+1)'(NREQ);
            end
            if (!w_found && w_elig[w_idx[c_IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[c_IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= c_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = c_IDLE;
        case (r_fsm)
            c_IDLE:  w_fsm_next = w_found ? c_ISSUE : c_IDLE;
            c_ISSUE: w_fsm_next = w_found ? c_ISSUE : c_IDLE;
            default: w_fsm_next = c_IDLE;
        endcase
    end

    always_comb begin
        bus.gnt       = '0;
        bus.rnd_valid = 1'b0;
        if (r_fsm == c_ISSUE) begin
            bus.gnt[r_rnd_id] = 1'b1;
            bus.rnd_valid     = 1'b1;
        end
    end

    assign bus.rnd_data = r_rnd_data;
    assign bus.rnd_id   = r_rnd_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rnd_data <= 32'h0;
            r_rnd_id   <= '0;
            r_last     <= c_IDW'(NREQ - 1);
            for (int i = 0; i < NREQ; i++) begin
                r_prng[i] <= DEFAULT_SEED + 32'(i);
            end
        end else begin
            if (w_found) begin
                r_rnd_data <= w_step;
                r_rnd_id   <= w_win;
                r_last     <= w_win;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.seed_we[i]) begin
                    r_prng[i] <= w_seed;
                end else if (w_found && (w_win == c_IDW'(i))) begin
                    r_prng[i] <= w_step;
                end
            end
        end
    end

`ifdef PRNG_SHARE_STATS_EN
    logic [15:0] r_cnt [NREQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                r_cnt[i] <= 16'h0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.seed_we[i]) begin
                    r_cnt[i] <= 16'h0;
                end else if (w_found && (w_win == c_IDW'(i)) && (r_cnt[i] != 16'hFFFF)) begin
                    r_cnt[i] <= r_cnt[i] + 16'h1;
                end
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        assign gnt_count[g*16 +: 16] = r_cnt[g];
    end
`endif
endmodule
`default_nettype wire

// File: doc/prng_share_ctrl.md
# prng_share_ctrl

Shared pseudo-random number generator with per-requester streams. One xorshift32 datapath is time-shared among NREQ requesters by a round-robin arbiter. Each requester has its own private 32-bit state register, so one requester's draws or reseeds never disturb another's sequence. Sits between stimulus/traffic agents and any logic needing reproducible, independently seedable random values.

## Interface
- NREQ, 3, number of requesters (1..8)
- DEFAULT_SEED, 32'h0000_0001, reset seed base; requester i resets to DEFAULT_SEED+i (must be nonzero for all i)
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- req  input  NREQ  per-requester draw request, sampled every clk
- seed_we  input  NREQ  per-requester reseed strobe
- seed_data  input  32  seed value for every asserted seed_we bit
- gnt  output  NREQ  one-hot grant pulse, registered
- rnd_valid  output  1  rnd_data/rnd_id valid this cycle
- rnd_data  output  32  drawn value (new state of granted requester)
- rnd_id  output  $clog2(NREQ) (min 1)  index of granted requester

## Operation
- Step function, 32-bit wrap: x ^= x<<13; x ^= x>>17; x ^= x<<5.
- Each cycle: eligible = req & ~seed_we. Pick one eligible bit round-robin, starting the search at (last_granted+1) mod NREQ. After reset, last_granted = NREQ-1, so requester 0 has first priority.
- Winner w: state[w] <= step(state[w]). Registered outputs: gnt = 1<<w, rnd_valid = 1, rnd_data = step(state[w]), rnd_id = w. last_granted <= w.
- No eligible requester: gnt = 0, rnd_valid = 0. rnd_data and rnd_id hold their last values. last_granted is unchanged.
- Reseed: seed_we[i] writes state[i] <= (seed_data==0 ? DEFAULT_SEED : seed_data). A zero seed is illegal for xorshift and is remapped.
- Reseed and req on the same requester in the same cycle: the reseed wins and no grant goes to that requester that cycle. The next draw uses the new seed.
- Several seed_we bits in one cycle all load the same seed_data.
- Internal states: IDLE (no eligible request) and ISSUE (grant registered). There is no multi-cycle occupancy; ISSUE may repeat back-to-back.

## Timing
- Latency: req sampled at edge t gives gnt, rnd_valid and rnd_data valid after edge t+1, i.e. 1 cycle.
- Throughput: one draw per cycle aggregate. A lone requester holding req high is granted every cycle.
- Handshake: req is level and re-sampled every cycle. A requester wanting exactly one value must drop req in the cycle it sees gnt. req still high in that cycle counts as a new request.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,..,NREQ-1,0; a requester waits at most NREQ-1 cycles.
- Reset values (asynchronous): gnt=0, rnd_valid=0, rnd_data=0, rnd_id=0, state[i]=DEFAULT_SEED+i, last_granted=NREQ-1.
- Reset mid-operation: all outputs clear immediately and the in-flight grant is discarded. After rst deasserts, the first grant is not visible until one edge after req is sampled.
- seed_we takes effect at the edge it is sampled. A draw one cycle later already uses the new state.

## Configuration
- PRNG_SHARE_STATS_EN defined: adds output gnt_count [NREQ*16-1:0], a 16-bit grant counter per requester in slice i.
  - Increments on each gnt[i] and saturates at 16'hFFFF.
  - Cleared by rst and by seed_we[i].
- PRNG_SHARE_STATS_EN undefined: the port and counters are absent; all other behaviour is identical.

## Test plan
- Reset defaults: after rst, req=3'b001 for one cycle -> next cycle gnt=3'b001, rnd_id=0, rnd_data=32'h0004_2021. Repeat the one-cycle pulse -> rnd_data=32'h0408_0601.
- Independent streams: reset, then request 1 alone -> rnd_data=32'h0008_4042. Then request 0 alone -> 32'h0004_2021, unaffected by requester 1's draw.
- Round-robin: hold req=3'b111 for 6 cycles -> rnd_id sequence 0,1,2,0,1,2, one gnt bit per cycle, no idle gaps.
- Reseed and zero seed:
  - seed_we=3'b010 with seed_data=1, then draw requester 1 -> 32'h0004_2021.
  - seed_data=0 -> state becomes DEFAULT_SEED, so the same value 32'h0004_2021.
  - seed_we[0] and req[0] in the same cycle -> no gnt that cycle, and the next grant returns step(new seed).
- Async reset mid-stream: with req=3'b111, assert rst between edges -> gnt, rnd_valid and rnd_data go to 0 without waiting for clk. After release, requester 0 is granted first and returns 32'h0004_2021.
- With PRNG_SHARE_STATS_EN: 5 grants to requester 2 -> gnt_count[47:32]=5. Then seed_we[2] -> 0. Force 65536 grants -> holds 16'hFFFF.
